// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer and flag control for an asynchronous FIFO: binary/Gray
// write pointer, synchronized read pointer, full/almost-full, level and overflow.
module fifo_wptr_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   rptr_gray,
  input  logic              ovf_clr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AFULL_V = (ADDR_W+1)'(AFULL_LVL);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [ADDR_W:0] rq1;
  logic [ADDR_W:0] rq2;
  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] bnext;
  logic [ADDR_W:0] gnext;
  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] full_cmp;

  // Stage p0: combinational next-pointer, full compare and level
  always_comb begin
    wen      = winc & ~wfull;
    bnext    = wbin + {{ADDR_W{1'b0}}, wen};
    gnext    = bin2gray(bnext);
    // Full when the write pointer has lapped the read pointer by exactly DEPTH:
    // in Gray terms the top two bits differ and the rest match.
    full_cmp = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
    rbin_s   = gray2bin(rq2);
    wlevel   = wbin - rbin_s;
  end

  assign waddr        = wbin[ADDR_W-1:0];
  assign walmost_full = (wlevel >= AFULL_V);

  // Stage p1: synchronizer, pointers and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1       <= '0;
      rq2       <= '0;
      wbin      <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rq1       <= rptr_gray;
      rq2       <= rq1;
      wbin      <= bnext;
      wptr_gray <= gnext;
      wfull     <= (gnext == full_cmp);
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl (ADDR_W=4, AFULL_LVL=14): reset, fill,
// overflow, drain visibility, async reset mid-fill and pointer wrap.
module tb_fifo_wptr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       winc;
  logic [4:0] rptr_gray;
  logic       ovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  fifo_wptr_ctrl #(.ADDR_W(4), .AFULL_LVL(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .ovf_clr      (ovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] g5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".wen"}, 32'(wen), 0);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wptr_gray"}, 32'(wptr_gray), 0);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".wafull"}, 32'(walmost_full), 0);
    chk({tag, ".wlevel"}, 32'(wlevel), 0);
    chk({tag, ".overflow"}, 32'(overflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; winc = 1'b0; ovf_clr = 1'b0; rptr_gray = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive inputs on the falling edge, then step over one rising edge
  task automatic step(input logic w, input logic c, input logic [4:0] rp);
    @(negedge clk);
    winc = w; ovf_clr = c; rptr_gray = rp;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] prev_g;

  initial begin
    rst_n = 1'b0; winc = 1'b0; ovf_clr = 1'b0; rptr_gray = 5'd0;
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 16 entries with the read pointer held at zero
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      winc = 1'b1;
      #1;
      chk($sformatf("fill%0d.wen", i), 32'(wen), 1);
      chk($sformatf("fill%0d.waddr", i), 32'(waddr), 32'(i));
      @(posedge clk);
      #1;
      chk($sformatf("fill%0d.wlevel", i), 32'(wlevel), 32'(i + 1));
      chk($sformatf("fill%0d.wafull", i), 32'(walmost_full), (i + 1 >= 14) ? 1 : 0);
      chk($sformatf("fill%0d.wfull", i), 32'(wfull), (i == 15) ? 1 : 0);
    end
    chk("fill.wptr_gray", 32'(wptr_gray), 32'h18);

    // Attempted write while full
    @(negedge clk);
    winc = 1'b1;
    #1;
    chk("ovf.wen", 32'(wen), 0);
    chk("ovf.waddr", 32'(waddr), 0);
    @(posedge clk);
    #1;
    chk("ovf.set", 32'(overflow), 1);
    chk("ovf.wlevel_hold", 32'(wlevel), 16);
    chk("ovf.wptr_hold", 32'(wptr_gray), 32'h18);
    step(1'b0, 1'b1, 5'd0);
    chk("ovf.clr", 32'(overflow), 0);
    step(1'b1, 1'b1, 5'd0);
    chk("ovf.set_wins", 32'(overflow), 1);
    step(1'b0, 1'b1, 5'd0);
    chk("ovf.clr2", 32'(overflow), 0);

    // Read pointer jumps to 4 while full
    step(1'b0, 1'b0, 5'b00110);
    chk("drain.e1.wlevel", 32'(wlevel), 16);
    chk("drain.e1.wfull", 32'(wfull), 1);
    step(1'b0, 1'b0, 5'b00110);
    chk("drain.e2.wlevel", 32'(wlevel), 12);
    chk("drain.e2.wfull", 32'(wfull), 1);
    step(1'b0, 1'b0, 5'b00110);
    chk("drain.e3.wfull", 32'(wfull), 0);
    @(negedge clk);
    winc = 1'b1;
    #1;
    chk("drain.wen", 32'(wen), 1);
    chk("drain.waddr", 32'(waddr), 0);
    @(posedge clk);
    #1;
    chk("drain.wlevel", 32'(wlevel), 13);
    chk("drain.wfull", 32'(wfull), 0);
    chk("drain.wafull", 32'(walmost_full), 0);

    // Async reset mid-fill at level 9
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 5'd0);
    chk("mid.wlevel", 32'(wlevel), 9);
    @(negedge clk);
    winc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    winc = 1'b1;
    #1;
    chk("refill.waddr", 32'(waddr), 0);
    @(posedge clk);
    #1;
    chk("refill.wlevel", 32'(wlevel), 1);

    // Wrap with the read pointer trailing by two writes
    do_reset();
    prev_g = 5'd0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, g5((k >= 2) ? k - 2 : 0));
      chk($sformatf("wrap%0d.wfull", k), 32'(wfull), 0);
      chk($sformatf("wrap%0d.gray", k), 32'(wptr_gray), 32'(g5(k + 1)));
      chk($sformatf("wrap%0d.onebit", k), 32'($countones(wptr_gray ^ prev_g)), 1);
      if (k >= 5) chk($sformatf("wrap%0d.wlevel", k), 32'(wlevel), 4);
      if (k == 30) chk("wrap.g31", 32'(wptr_gray), 32'h10);
      if (k == 31) begin
        chk("wrap.g0", 32'(wptr_gray), 0);
        chk("wrap.waddr0", 32'(waddr), 0);
      end
      prev_g = wptr_gray;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_ctrl.md
FIFO_WPTR_CTRL -- requirements
Module: fifo_wptr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, FIFO address width (DEPTH = 2^ADDR_W).
REQ-002 The block SHALL have parameter AFULL_LVL, default 14, fill level at or above which walmost_full asserts.
REQ-003 The block SHALL have port clk  input  1  write-domain clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port winc  input  1  write request from producer.
REQ-006 The block SHALL have port rptr_gray  input  ADDR_W+1  read pointer, Gray-coded, from the read clock domain (asynchronous to clk).
REQ-007 The block SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 The block SHALL have port wen  output  1  write strobe to FIFO memory.
REQ-009 The block SHALL have port waddr  output  ADDR_W  write address to FIFO memory.
REQ-010 The block SHALL have port wptr_gray  output  ADDR_W+1  registered Gray write pointer, sent to the read domain.
REQ-011 The block SHALL have port wfull  output  1  registered full flag.
REQ-012 The block SHALL have port walmost_full  output  1  fill level >= AFULL_LVL.
REQ-013 The block SHALL have port wlevel  output  ADDR_W+1  fill level as seen in the write domain, range 0..DEPTH.
REQ-014 The block SHALL have port overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-015 rptr_gray SHALL pass through a 2-flop synchronizer (rq1, rq2); no other logic SHALL read rptr_gray directly.
REQ-016 wen SHALL be combinational: winc AND NOT wfull.
REQ-017 Internal binary pointer wbin (ADDR_W+1 bits) SHALL increment by 1 on each clock edge with wen=1, wrapping 2^(ADDR_W+1)-1 -> 0; otherwise it holds.
REQ-018 waddr SHALL equal wbin[ADDR_W-1:0].
REQ-019 wptr_gray SHALL be registered as bnext XOR (bnext >> 1), where bnext is the next-cycle wbin; each pointer increment SHALL change exactly one bit of wptr_gray.
REQ-020 wfull SHALL be registered as (Gray of bnext) == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}.
REQ-021 rbin_s SHALL be the Gray-to-binary conversion of rq2, with bit i = XOR of rq2[ADDR_W:i].
REQ-022 wlevel SHALL be (wbin - rbin_s) mod 2^(ADDR_W+1), combinational from registered values; wlevel SHALL never exceed DEPTH.
REQ-023 walmost_full SHALL be combinational: wlevel >= AFULL_LVL.
REQ-024 Latency: a write sets wfull/wptr_gray/wlevel at the same edge that advances wbin; a rptr_gray change reaches rq2 after 2 edges, wlevel after 2 edges, and wfull after 3 edges.
REQ-025 winc while wfull=1 SHALL NOT write and SHALL NOT move any pointer; overflow SHALL set at that edge.
REQ-026 overflow SHALL clear on an edge with ovf_clr=1; if set and clear conditions coincide, set SHALL win.
REQ-027 Full assertion SHALL be exact (no write lost at DEPTH); deassertion SHALL be pessimistic only by synchronizer latency.

Reset
REQ-028 rst_n low SHALL asynchronously clear rq1, rq2, wbin, wptr_gray, wfull, overflow to 0; wen, waddr, wlevel, walmost_full SHALL then be 0.
REQ-029 Deassertion of rst_n SHALL take effect at the next rising clk edge; reset mid-operation SHALL discard all pointer state with no partial write.

Verification (ADDR_W=4, AFULL_LVL=14)
REQ-030 Reset: rst_n=0, rptr_gray=0 -> all outputs 0, with no clock required.
REQ-031 Fill: rptr_gray=0, 16 consecutive winc -> waddr 0..15, walmost_full=1 after the 14th write, wfull=1 and wlevel=16 after the 16th write, wptr_gray=5'b11000.
REQ-032 Overflow: 17th winc while full -> wen=0, waddr stays 0, overflow=1 next edge; then ovf_clr=1 for one cycle -> overflow=0; winc and ovf_clr on the same edge -> overflow=1.
REQ-033 Drain visibility: while full, rptr_gray=5'b00110 (binary 4) -> wlevel=12 after 2 edges, wfull=0 after 3 edges, next winc writes waddr 0.
REQ-034 Wrap: read pointer tracks at 2-entry lag across 40 writes -> wbin wraps 31->0, wptr_gray goes 5'b10000 -> 5'b00000, every step a single-bit Gray change, wfull never set.
REQ-035 Async reset mid-fill: rst_n pulsed low between edges at wlevel=9 -> all outputs 0 immediately, refill restarts at waddr 0.
